hex_2_ascii_tx: RTL
===================

Name: hex_2_ascii_tx

Overview:
- Takes a binary word and emits it as a stream of uppercase ASCII hex characters, most-significant nibble first, with optional CR/LF after the last digit.
- Each character is offered on a valid/ready byte interface that feeds the UART transmitter.
- Performs the encoding opposite to the receive-side ASCII-to-nibble conversion, so a value typed on the terminal can be echoed back.

Parameters:
- NIBBLES, 2, number of hex digits per word; data width is 4*NIBBLES; legal range 1..8.
- APPEND_CRLF, 1, when 1 send 8'd13 then 8'd10 after the last digit; when 0 send digits only.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- data_in  input  4*NIBBLES  word to transmit; sampled only when start is accepted.
- start  input  1  request to send data_in.
- ready  output  1  high when idle and able to accept start.
- ascii_out  output  8  current ASCII character.
- ascii_valid  output  1  ascii_out holds a character awaiting acceptance.
- ascii_ready  input  1  UART TX accepts the character this cycle when ascii_valid is also high.
- done  output  1  single-cycle pulse when a full word (including CR/LF) has been accepted.

Behaviour:
- Reset (async, any time, mid-word included):
  - state=IDLE; ready=1; ascii_valid=0; ascii_out=8'd0; done=0.
  - Internal shift register and counter are cleared.
  - A partially sent word is abandoned and not resumed.
- States: IDLE, DIGIT, CR, LF.
- IDLE:
  - ready=1, ascii_valid=0.
  - start=1 at an edge: data_in is latched, digit counter=NIBBLES-1, state moves to DIGIT.
  - ready goes low and ascii_valid goes high in the next cycle; latency from the start edge to the first valid character is 1 cycle.
- DIGIT:
  - ascii_out = encode(top nibble of the latched word).
  - Encoding: 0..9 map to 8'd48..8'd57; A..F map to 8'd65..8'd70 (uppercase only).
  - On handshake (ascii_valid & ascii_ready) with counter>0: shift the word left by 4, decrement the counter, stay in DIGIT. The next character is valid in the next cycle with no bubble.
  - On handshake with counter==0: go to CR if APPEND_CRLF=1; otherwise go to IDLE and pulse done.
- CR: ascii_out=8'd13. Handshake moves to LF.
- LF: ascii_out=8'd10. Handshake moves to IDLE and pulses done.
- done:
  - Registered; high for exactly one cycle, the first IDLE cycle after the final handshake.
  - ready=1 in that same cycle.
  - A start in the done cycle is accepted normally, so back-to-back words have a single idle cycle between them.
- Hold rule: while ascii_valid=1 and ascii_ready=0, ascii_out and ascii_valid stay stable. ascii_valid never drops without a handshake, except on reset.
- start while ready=0: ignored; data_in is not re-sampled.
- ascii_ready while ascii_valid=0: no effect.
- ascii_out in IDLE: 8'd0.
- Data changes: data_in may change freely after the start edge; the transmitted word is the latched copy.

Test Plan:
1. Reset, then data_in=8'h3F, start for 1 cycle, ascii_ready tied to 1 -> characters 8'd51, 8'd70, 8'd13, 8'd10 on four consecutive cycles starting 1 cycle after start; done pulses once on the following cycle; ready=1 there.
2. Backpressure: data_in=8'hA5, ascii_ready toggled 0,0,1,0,1,1,1 -> sequence 8'd65, 8'd53, 8'd13, 8'd10. Each character stays stable through the ready-low cycles and none is duplicated or dropped.
3. NIBBLES=4, APPEND_CRLF=0, data_in=16'h09BC -> 8'd48, 8'd57, 8'd66, 8'd67 and no CR/LF; done pulses after 8'd67 is accepted.
4. start pulsed again while transmitting 8'h12 with data_in changed to 8'hFF -> output is still 8'd49, 8'd50, 8'd13, 8'd10; exactly one done pulse.
5. rst asserted asynchronously between clock edges while the second digit is pending -> ascii_valid=0, ascii_out=0, ready=1 immediately without waiting for a clock edge. A new start with 8'h00 then produces 8'd48, 8'd48, 8'd13, 8'd10.
6. Back-to-back: start held high continuously with 8'h7E -> the second word's first character is valid 2 cycles after the first word's LF handshake; both words are sent complete.

Source files
------------

// File: rtl/hex_2_ascii_tx.sv
//------------------------------------------------------------------------------
// Module      : hex_2_ascii_tx
// Description : Streams a binary word as uppercase ASCII hex characters,
//               MSB nibble first, with optional CR/LF, over valid/ready.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hex_2_ascii_tx #(
  parameter int NIBBLES     = 2,
  parameter int APPEND_CRLF = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*NIBBLES-1:0]   data_in,
  input  logic                   start,
  output logic                   ready,
  output logic [7:0]             ascii_out,
  output logic                   ascii_valid,
  input  logic                   ascii_ready,
  output logic                   done
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIGIT = 2'd1,
    S_CR    = 2'd2,
    S_LF    = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [W-1:0]    r_shift;
  logic [CW-1:0]   r_cnt;
  logic            r_done;
  logic            w_hs;
  logic            w_accept;
  logic            w_shift_en;
  logic            w_finish;
  logic [3:0]      w_nibble;
  logic [7:0]      w_digit_char;

  assign w_hs     = ascii_valid & ascii_ready;
  assign w_nibble = r_shift[W-1 -: 4];

  // Digits 10..15 land on 'A'..'F' (65..70): 55 + nibble.
  assign w_digit_char = (w_nibble < 4'd10) ? (8'd48 + {4'd0, w_nibble})
                                           : (8'd55 + {4'd0, w_nibble});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_shift_en   = 1'b0;
    w_finish     = 1'b0;
    ready        = 1'b0;
    ascii_valid  = 1'b0;
    ascii_out    = 8'd0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = S_DIGIT;
        end
      end
      S_DIGIT: begin
        ascii_valid = 1'b1;
        ascii_out   = w_digit_char;
        if (w_hs) begin
          if (r_cnt != '0) begin
            w_shift_en = 1'b1;
          end else if (APPEND_CRLF != 0) begin
            w_next_state = S_CR;
          end else begin
            w_next_state = S_IDLE;
            w_finish     = 1'b1;
          end
        end
      end
      S_CR: begin
        ascii_valid = 1'b1;
        ascii_out   = 8'd13;
        if (w_hs) begin
          w_next_state = S_LF;
        end
      end
      S_LF: begin
        ascii_valid = 1'b1;
        ascii_out   = 8'd10;
        if (w_hs) begin
          w_next_state = S_IDLE;
          w_finish     = 1'b1;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Word latch, digit counter and the registered completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_shift <= data_in;
        r_cnt   <= CW'(NIBBLES - 1);
      end else if (w_shift_en) begin
        r_shift <= r_shift << 4;
        r_cnt   <= r_cnt - 1'b1;
      end
    end
  end

  assign done = r_done;

endmodule

`default_nettype wire
